// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package imem_pkg;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_512x8_wr.sv
// Byte-wide instruction memory: one synchronous byte-write port and a
// combinational big-endian 4-byte read whose addresses wrap modulo DEPTH.
module mem_512x8_wr #(
    parameter int DEPTH  = imem_pkg::DEPTH,
    parameter int ADDR_W = imem_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_idx [4];
    logic [ADDR_W:0]   rd_ext;

    // NOTE: the array has no reset branch; clearing it would force flops
    // instead of RAM and contents must survive a loader reset anyway.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_ext = '0;
        for (int k = 0; k < 4; k++) begin
            rd_ext = {1'b0, raddr} + (ADDR_W+1)'(k);
            if (rd_ext >= DEPTH_X) begin
                rd_ext = rd_ext - DEPTH_X;
            end
            rd_idx[k] = rd_ext[ADDR_W-1:0];
        end
    end

    assign rdata = {mem[rd_idx[0]], mem[rd_idx[1]], mem[rd_idx[2]], mem[rd_idx[3]]};

endmodule

// File: rtl/imem_loader.sv
// Loads 32-bit big-endian words into byte memory, one byte per cycle.
// Optional running word checksum output: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = imem_pkg::DEPTH,
    parameter int ADDR_W = imem_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [31:0]       WordIn,
    input  logic              WordValid,
    output logic              WordReady,
    input  logic              LastWord,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow,
    output logic [ADDR_W-1:0] WordCount,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [31:0]       RdData
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       Checksum
`endif
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    state_t state, state_nxt;

    // One extra pointer bit so advancing past the top never wraps to 0.
    logic [ADDR_W:0] ptr;
    logic [ADDR_W:0] byte_addr;
    logic [1:0]      byte_idx;
    logic [31:0]     word_q;
    logic            last_q;
    logic            addr_oob;

    logic load_session, accept_word, write_en, word_done, set_ovf;

    assign byte_addr = ptr + {{(ADDR_W-1){1'b0}}, byte_idx};
    assign addr_oob  = byte_addr > LAST_ADDR;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt    = state;
        load_session = 1'b0;
        accept_word  = 1'b0;
        write_en     = 1'b0;
        word_done    = 1'b0;
        set_ovf      = 1'b0;
        WordReady    = 1'b0;
        Busy         = 1'b1;
        Done         = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    load_session = 1'b1;
                    state_nxt    = ACCEPT;
                end
            end
            ACCEPT: begin
                WordReady = 1'b1;
                if (WordValid) begin
                    accept_word = 1'b1;
                    state_nxt   = WRITE;
                end
            end
            WRITE: begin
                if (addr_oob) begin
                    set_ovf   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    write_en = 1'b1;
                    if (byte_idx == 2'd3) begin
                        word_done = 1'b1;
                        state_nxt = last_q ? DONE : ACCEPT;
                    end
                end
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr       <= '0;
            byte_idx  <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            WordCount <= '0;
            Overflow  <= 1'b0;
        end else begin
            if (load_session) begin
                ptr       <= {1'b0, BaseAddr};
                WordCount <= '0;
                Overflow  <= 1'b0;
            end
            if (accept_word) begin
                word_q   <= WordIn;
                last_q   <= LastWord;
                byte_idx <= '0;
            end
            // Shift the latched word so the next byte is always at [31:24].
            if (write_en) begin
                word_q   <= {word_q[23:0], 8'h00};
                byte_idx <= byte_idx + 2'd1;
            end
            if (word_done) begin
                ptr       <= ptr + (ADDR_W+1)'(4);
                WordCount <= WordCount + ADDR_W'(1);
            end
            if (set_ovf) begin
                Overflow <= 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (Reset || load_session) begin
            Checksum <= '0;
        end else if (accept_word) begin
            Checksum <= Checksum + WordIn;
        end
    end
`else
    // Checksum port and accumulator are not built.
`endif

    mem_512x8_wr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .Clk   (Clk),
        .we    (write_en & ~Reset),
        .waddr (byte_addr[ADDR_W-1:0]),
        .wdata (word_q[31:24]),
        .raddr (RdAddr),
        .rdata (RdData)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default 512-byte build).
module tb_imem_loader;

    localparam int ADDR_W = 9;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [ADDR_W-1:0] BaseAddr;
    logic [31:0]       WordIn;
    logic              WordValid;
    logic              WordReady;
    logic              LastWord;
    logic              Busy;
    logic              Done;
    logic              Overflow;
    logic [ADDR_W-1:0] WordCount;
    logic [ADDR_W-1:0] RdAddr;
    logic [31:0]       RdData;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       Checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    imem_loader dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .WordIn    (WordIn),
        .WordValid (WordValid),
        .WordReady (WordReady),
        .LastWord  (LastWord),
        .Busy      (Busy),
        .Done      (Done),
        .Overflow  (Overflow),
        .WordCount (WordCount),
        .RdAddr    (RdAddr),
        .RdData    (RdData)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .Checksum  (Checksum)
`endif
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        Start    = 1'b1;
        BaseAddr = base;
        tick();
        Start = 1'b0;
    endtask

    // Present a word and wait (bounded) until the edge that accepts it.
    task automatic accept_word(input logic [31:0] w, input logic last);
        int waited = 0;
        WordIn    = w;
        LastWord  = last;
        WordValid = 1'b1;
        while (WordReady !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (WordReady !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: WordReady=%b after %0d cycles, required 1", WordReady, waited);
        end
        tick();
        WordValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        accept_word(w, last);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({WordReady, Busy, Done, Overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/busy/done/ovf=%b required 0000", {WordReady, Busy, Done, Overflow});
        end
        n_checks++;
        if (WordCount !== '0) begin
            n_fail++;
            $display("FAIL reset_count: WordCount=%0d required 0", WordCount);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_start(9'd0);
        n_checks++;
        if (WordReady !== 1'b1 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept_state: ready=%b busy=%b required 1 1", WordReady, Busy);
        end
        accept_word(32'hDEADBEEF, 1'b1);
        // Done follows the four write edges: sixth cycle counting the accept cycle as the first.
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (Done !== (i == 4)) begin
                n_fail++;
                $display("FAIL single_done_timing: edge %0d Done=%b required %b", i, Done, (i == 4));
            end
        end
        RdAddr = 9'd0;
        #1;
        n_checks++;
        if (RdData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_rddata: got %h required deadbeef", RdData);
        end
        n_checks++;
        if (WordCount !== 9'd1) begin
            n_fail++;
            $display("FAIL single_count: WordCount=%0d required 1", WordCount);
        end
        tick();
        n_checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: done=%b busy=%b required 0 0", Done, Busy);
        end
    endtask

    // Overwrite DEADBEEF at address 0 and watch each byte land on its edge.
    task automatic test_visibility();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h01ADBEEF, 32'h0102BEEF, 32'h010203EF, 32'h01020304};
        RdAddr = 9'd0;
        do_start(9'd0);
        accept_word(32'h01020304, 1'b1);
        n_checks++;
        if (RdData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL vis_before: got %h required deadbeef", RdData);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (RdData !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL vis_byte%0d: got %h required %h", i, RdData, exp_seq[i]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        int k = 0;
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_start(9'd8);
        WordValid = 1'b1;
        WordIn    = words[0];
        LastWord  = 1'b0;
        for (int c = 0; c < 15; c++) begin
            n_checks++;
            if (WordReady !== (c % 5 == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready: cycle %0d WordReady=%b required %b", c, WordReady, (c % 5 == 0));
            end
            if (WordReady === 1'b1) k++;
            tick();
            if (k < 3) begin
                WordIn   = words[k];
                LastWord = (k == 2);
            end
        end
        WordValid = 1'b0;
        n_checks++;
        if (Done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: Done=%b required 1", Done);
        end
        n_checks++;
        if (WordCount !== 9'd3) begin
            n_fail++;
            $display("FAIL b2b_count: WordCount=%0d required 3", WordCount);
        end
        for (int i = 0; i < 3; i++) begin
            RdAddr = 9'(8 + 4 * i);
            #1;
            n_checks++;
            if (RdData !== words[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h required %h", i, RdData, words[i]);
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        do_start(9'd508);
        send_word(32'hA1A2A3A4, 1'b0);
        accept_word(32'hB1B2B3B4, 1'b1);
        tick();
        n_checks++;
        if (Done !== 1'b1 || Overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flags: done=%b ovf=%b required 1 1", Done, Overflow);
        end
        n_checks++;
        if (WordCount !== 9'd1) begin
            n_fail++;
            $display("FAIL ovf_count: WordCount=%0d required 1", WordCount);
        end
        RdAddr = 9'd508;
        #1;
        n_checks++;
        if (RdData !== 32'hA1A2A3A4) begin
            n_fail++;
            $display("FAIL ovf_first_word: got %h required a1a2a3a4", RdData);
        end
        RdAddr = 9'd0;
        #1;
        n_checks++;
        if (RdData !== 32'h01020304) begin
            n_fail++;
            $display("FAIL ovf_no_wrap_write: got %h required 01020304", RdData);
        end
        RdAddr = 9'd510;
        #1;
        n_checks++;
        if (RdData !== 32'hA3A40102) begin
            n_fail++;
            $display("FAIL rd_wrap: got %h required a3a40102", RdData);
        end
        tick();
        n_checks++;
        if (Overflow !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf=%b busy=%b done=%b required 1 0 0", Overflow, Busy, Done);
        end
    endtask

    task automatic test_abort();
        do_start(9'd8);
        n_checks++;
        if (Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared_by_start: Overflow=%b required 0", Overflow);
        end
        accept_word(32'h5A5B5C5D, 1'b1);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || WordCount !== '0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b count=%0d required 0 0 0", Busy, Done, WordCount);
        end
        Reset = 1'b0;
        tick();
        n_checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b busy=%b required 0 0", Done, Busy);
        end
        RdAddr = 9'd8;
        #1;
        n_checks++;
        if (RdData !== 32'h5A5B1111) begin
            n_fail++;
            $display("FAIL abort_partial: got %h required 5a5b1111", RdData);
        end
    endtask

    task automatic test_start_ignored();
        do_start(9'd40);
        accept_word(32'h0A0B0C0D, 1'b0);
        tick();
        Start    = 1'b1;
        BaseAddr = 9'd100;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Start    = 1'b1;
        BaseAddr = 9'd200;
        tick();
        Start = 1'b0;
        n_checks++;
        if (WordReady !== 1'b1 || WordCount !== 9'd1) begin
            n_fail++;
            $display("FAIL start_busy_state: ready=%b count=%0d required 1 1", WordReady, WordCount);
        end
        send_word(32'h0E0F1011, 1'b1);
        n_checks++;
        if (Done !== 1'b1 || WordCount !== 9'd2) begin
            n_fail++;
            $display("FAIL start_busy_done: done=%b count=%0d required 1 2", Done, WordCount);
        end
        RdAddr = 9'd44;
        #1;
        n_checks++;
        if (RdData !== 32'h0E0F1011) begin
            n_fail++;
            $display("FAIL start_busy_ptr: got %h required 0e0f1011", RdData);
        end
        tick();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_start(9'd64);
        send_word(32'hFFFFFFFF, 1'b0);
        send_word(32'h00000002, 1'b1);
        n_checks++;
        if (Checksum !== 32'h00000001) begin
            n_fail++;
            $display("FAIL checksum: got %h required 00000001", Checksum);
        end
        tick();
    endtask
`endif

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        BaseAddr  = '0;
        WordIn    = '0;
        WordValid = 1'b0;
        LastWord  = 1'b0;
        RdAddr    = '0;
        test_reset();
        test_single();
        test_visibility();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
